// File: rtl/ili_bus_master.sv
// Avalon-MM slave that runs 8080-style command/data write and data read cycles
// on an ILI9341 parallel port, with strobe timing from parameterized cycle counts.
module ili_bus_master #(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_WRL   = 2,
    parameter int unsigned T_WRH   = 2,
    parameter int unsigned T_RDL   = 18,
    parameter int unsigned T_RDH   = 5,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire  [7:0]  lcd_db,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic        lcd_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI
    } state_t;

    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_WRL   = CW'(T_WRL - 1);
    localparam logic [CW-1:0] L_WRH   = CW'(T_WRH - 1);
    localparam logic [CW-1:0] L_RDL   = CW'(T_RDL - 1);
    localparam logic [CW-1:0] L_RDH   = CW'(T_RDH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          dir_rd_q, dir_rd_d;
    logic          rs_q, rs_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          rd_n_q, rd_n_d;
    logic          oe_q, oe_d;
    logic          rst_n_q, rst_n_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overrun_q, overrun_d;
    logic [31:0]   readdata_q, readdata_d;

    logic wr_en, start, busy, last;

    logic unused;
    assign unused = ^{read_n, writedata[31:9]};

    always_comb begin
        wr_en = chipselect & ~write_n;
        start = wr_en && (address != 2'd3);
        busy  = (state_q != S_IDLE);

        case (state_q)
            S_SETUP: last = (cnt_q == L_SETUP);
            S_WR_LO: last = (cnt_q == L_WRL);
            S_WR_HI: last = (cnt_q == L_WRH);
            S_RD_LO: last = (cnt_q == L_RDL);
            S_RD_HI: last = (cnt_q == L_RDH);
            default: last = 1'b0;
        endcase

        state_d    = state_q;
        cnt_d      = last ? '0 : cnt_q + 1'b1;
        byte_d     = byte_q;
        dir_rd_d   = dir_rd_q;
        rs_d       = rs_q;
        rst_n_d    = rst_n_q;
        rd_byte_d  = rd_byte_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d  = S_SETUP;
                    byte_d   = writedata[7:0];
                    rs_d     = (address != 2'd0);
                    dir_rd_d = (address == 2'd2);
                    if (address == 2'd2) rd_valid_d = 1'b0;
                end
            end
            S_SETUP: if (last) state_d = dir_rd_q ? S_RD_LO : S_WR_LO;
            S_WR_LO: if (last) state_d = S_WR_HI;
            S_WR_HI: if (last) state_d = S_IDLE;
            S_RD_LO: begin
                if (last) begin
                    state_d    = S_RD_HI;
                    rd_byte_d  = lcd_db;
                    rd_valid_d = 1'b1;
                end
            end
            S_RD_HI: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Starts while a transfer is in flight are dropped, not queued.
        if (start && busy) overrun_d = 1'b1;

        if (wr_en && (address == 2'd3)) begin
            rst_n_d = writedata[0];
            if (writedata[8]) overrun_d = 1'b0;
        end

        // Pins are registered from the next state so they switch with the FSM.
        cs_n_d = (state_d == S_IDLE);
        wr_n_d = (state_d != S_WR_LO);
        rd_n_d = (state_d != S_RD_LO);
        oe_d   = !dir_rd_d &&
                 ((state_d == S_SETUP) || (state_d == S_WR_LO) || (state_d == S_WR_HI));

        case (address)
            2'd0, 2'd1: readdata_d = {24'b0, rd_byte_q};
            2'd2:       readdata_d = 32'b0;
            default:    readdata_d = {29'b0, overrun_q, rd_valid_q, busy};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_q     <= 8'h00;
            dir_rd_q   <= 1'b0;
            rs_q       <= 1'b1;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            rst_n_q    <= 1'b0;
            rd_byte_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= 32'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            dir_rd_q   <= dir_rd_d;
            rs_q       <= rs_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            oe_q       <= oe_d;
            rst_n_q    <= rst_n_d;
            rd_byte_q  <= rd_byte_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    assign lcd_db    = oe_q ? byte_q : 8'bz;
    assign lcd_cs_n  = cs_n_q;
    assign lcd_rs    = rs_q;
    assign lcd_wr_n  = wr_n_q;
    assign lcd_rd_n  = rd_n_q;
    assign lcd_rst_n = rst_n_q;
    assign readdata  = readdata_q;

endmodule

// File: tb/tb_ili_bus_master.sv
// Directed bench for ili_bus_master: default-timing instance plus a fast-timing
// instance; the LCD bus is pulled up so an undriven bus reads 0xFF.
module tb_ili_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        cs, cs2;
    logic        write_n, read_n;
    logic [31:0] writedata;
    logic [31:0] readdata, readdata2;
    wire  [7:0]  lcd_db, lcd_db2;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n;
    logic        lcd_cs_n2, lcd_rs2, lcd_wr_n2, lcd_rd_n2, lcd_rst_n2;
    logic [7:0]  tb_byte = 8'h93;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_pu
        pullup pu1 (lcd_db[gi]);
        pullup pu2 (lcd_db2[gi]);
    end

    // Panel model: drives the bus only while the read strobe is low.
    assign lcd_db = (!lcd_rd_n) ? tb_byte : 8'bz;

    ili_bus_master dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(readdata), .lcd_db(lcd_db), .lcd_cs_n(lcd_cs_n),
        .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
        .lcd_rst_n(lcd_rst_n)
    );

    ili_bus_master #(.T_SETUP(1), .T_WRL(1), .T_WRH(1)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(readdata2), .lcd_db(lcd_db2), .lcd_cs_n(lcd_cs_n2),
        .lcd_rs(lcd_rs2), .lcd_wr_n(lcd_wr_n2), .lcd_rd_n(lcd_rd_n2),
        .lcd_rst_n(lcd_rst_n2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns just after a rising edge.
    task automatic avl_wr(input bit d2, input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write_n = 1'b0;
        if (d2) cs2 = 1'b1; else cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; cs2 = 1'b0; write_n = 1'b1;
    endtask

    task automatic avl_rd(input bit d2, input logic [1:0] a, output logic [31:0] v);
        address = a; read_n = 1'b0;
        @(posedge clk); #1;
        read_n = 1'b1;
        @(negedge clk);
        v = d2 ? readdata2 : readdata;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input bit d2);
        bit done = 1'b0;
        address = 2'd3;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (n > 1 && (d2 ? readdata2[0] : readdata[0]) == 1'b0) done = 1'b1;
        end
        if (!done) chk("wait_idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // Fast-instance monitor: cs_n low run lengths and bytes strobed on wr_n.
    int         run2 = 0;
    int         runs_q[$];
    logic [7:0] dat_q[$];
    initial forever begin
        @(negedge clk);
        if (!lcd_wr_n2) dat_q.push_back(lcd_db2);
        if (!lcd_cs_n2) run2++;
        else if (run2 != 0) begin
            runs_q.push_back(run2);
            run2 = 0;
        end
    end

    initial begin
        logic [31:0] v;
        logic [6:0]  cs_tr, wr_tr, busy_tr;
        int          wr_low, rd_low, cs_low, bad;
        logic [7:0]  exp2 [4];
        exp2[0] = 8'h11; exp2[1] = 8'h22; exp2[2] = 8'h33; exp2[3] = 8'h44;

        reset = 1'b1; cs = 1'b0; cs2 = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd0; writedata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Idle after reset
        @(negedge clk);
        chk("idle_pins", {27'd0, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_rs}, 32'b11101);
        chk("idle_db", {24'd0, lcd_db}, 32'hFF);
        @(posedge clk); #1;
        avl_rd(1'b0, 2'd3, v);
        chk("idle_status", v, 32'h0);

        // Command write 0x2C with default timing
        avl_wr(1'b0, 2'd3, 32'h1);
        avl_wr(1'b0, 2'd0, 32'h2C);
        address = 2'd3;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cs_tr[k]   = lcd_cs_n;
            wr_tr[k]   = lcd_wr_n;
            busy_tr[k] = (k == 0) ? 1'b0 : readdata[0];
            if (k < 5 && lcd_db !== 8'h2C) bad++;
            if (k == 0) begin
                chk("cmd_rs", {31'd0, lcd_rs}, 32'd0);
                chk("cmd_rst_n", {31'd0, lcd_rst_n}, 32'd1);
            end
        end
        chk("cmd_cs_trace", {25'd0, cs_tr}, 32'b1100000);
        chk("cmd_wr_trace", {25'd0, wr_tr}, 32'b1111001);
        chk("cmd_busy_trace", {25'd0, busy_tr}, 32'b0111110);
        chk("cmd_db_hold", bad, 0);
        @(negedge clk);
        chk("cmd_db_release", {24'd0, lcd_db}, 32'hFF);
        @(posedge clk); #1;

        // Data write, second write while busy is dropped
        avl_wr(1'b0, 2'd1, 32'hA5);
        avl_wr(1'b0, 2'd1, 32'h5A);
        wr_low = 0; bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!lcd_wr_n) begin
                wr_low++;
                if (lcd_db !== 8'hA5 || lcd_rs !== 1'b1) bad++;
            end
        end
        chk("ovr_wr_pulses", wr_low, 2);
        chk("ovr_data_rs", bad, 0);
        @(posedge clk); #1;
        avl_rd(1'b0, 2'd3, v);
        chk("ovr_status", v, 32'h4);
        avl_wr(1'b0, 2'd3, 32'h101);
        avl_rd(1'b0, 2'd3, v);
        chk("ovr_cleared", v, 32'h0);

        // Read cycle, panel returns 0x93
        tb_byte = 8'h93;
        avl_wr(1'b0, 2'd2, 32'h3C);
        rd_low = 0; cs_low = 0; bad = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (!lcd_cs_n) cs_low++;
            if (!lcd_rd_n) begin
                rd_low++;
                if (lcd_db !== tb_byte) bad++;
            end else if (lcd_db !== 8'hFF) bad++;
        end
        chk("rd_low_cycles", rd_low, 18);
        chk("rd_cs_cycles", cs_low, 24);
        chk("rd_db_tristate", bad, 0);
        @(posedge clk); #1;
        avl_rd(1'b0, 2'd3, v);
        chk("rd_status", v, 32'h2);
        avl_rd(1'b0, 2'd0, v);
        chk("rd_byte", v, 32'h93);
        tb_byte = 8'h4E;
        avl_wr(1'b0, 2'd2, 32'h0);
        avl_rd(1'b0, 2'd3, v);
        chk("rd2_busy_status", v, 32'h1);
        wait_idle(1'b0);
        avl_rd(1'b0, 2'd1, v);
        chk("rd2_byte", v, 32'h4E);
        avl_rd(1'b0, 2'd3, v);
        chk("rd2_status", v, 32'h2);

        // Reset in the second WR_LO cycle
        avl_wr(1'b0, 2'd1, 32'h77);
        repeat (3) @(negedge clk);
        chk("mid_wr_low", {31'd0, lcd_wr_n}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_async_pins", {28'd0, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rst_n}, 32'b1110);
        chk("rst_async_db", {24'd0, lcd_db}, 32'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_low = 0; cs_low = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!lcd_wr_n) wr_low++;
            if (!lcd_cs_n) cs_low++;
        end
        chk("post_rst_wr", wr_low, 0);
        chk("post_rst_cs", cs_low, 0);
        @(posedge clk); #1;
        avl_rd(1'b0, 2'd3, v);
        chk("post_rst_status", v, 32'h0);

        // Fast timing instance, four polled data writes
        runs_q.delete(); dat_q.delete(); run2 = 0;
        for (int i = 0; i < 4; i++) begin
            avl_wr(1'b1, 2'd1, {24'd0, exp2[i]});
            wait_idle(1'b1);
        end
        repeat (3) @(posedge clk); #1;
        chk("fast_count", runs_q.size(), 4);
        chk("fast_bytes", dat_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fast_len%0d", i), (i < runs_q.size()) ? runs_q[i] : -1, 3);
            chk($sformatf("fast_dat%0d", i), (i < dat_q.size()) ? {24'd0, dat_q[i]} : 32'hFFFF, {24'd0, exp2[i]});
        end
        avl_rd(1'b1, 2'd3, v);
        chk("fast_status", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
